ternary_acc_sched: RTL and testbench

Burst-reduction scheduler that owns one 8-bit `ternary_adder_noincr` instance and uses it to reduce a variable-length stream of operand pairs to a single modulo-256 sum. Each cycle it feeds the adder the running accumulator plus two new operands. It uses the adder's carry-in once per burst, which lets callers fold in a two's-complement "+1" for subtraction. It sits between operand producers in the FPApprox datapath and the downstream result consumer, with valid/ready handshakes on both sides.

---
 rtl/ternary_acc_pkg.sv | 9 +
 rtl/ternary_adder_noincr.sv | 14 +
 rtl/ternary_acc_sched.sv | 121 ++++++++++++
 tb/tb_ternary_acc_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_acc_pkg.sv
// Shared types and widths for the ternary burst-reduction scheduler.
package ternary_acc_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} tacc_state_t;

   localparam int TACC_W      = 8;
   localparam int TACC_PERF_W = 16;

endpackage

// File: rtl/ternary_adder_noincr.sv
// Three-operand adder with carry-in; modulo-2^TACC_W result, no carry-out.
module ternary_adder_noincr
   import ternary_acc_pkg::*;
(
   input  logic [TACC_W-1:0] i_x,
   input  logic [TACC_W-1:0] i_y,
   input  logic [TACC_W-1:0] i_z,
   input  logic              i_cin,
   output logic [TACC_W-1:0] o_sum
);

   assign o_sum = i_x + i_y + i_z + TACC_W'(i_cin);

endmodule

// File: rtl/ternary_acc_sched.sv
// Reduces a burst of operand pairs to one modulo-256 sum through a shared ternary adder.
// Optional perf counters (perf_bursts, perf_trunc) are enabled by TERNARY_ACC_PERF_EN.
module ternary_acc_sched
   import ternary_acc_pkg::*;
#(
   parameter int MAX_BEATS = 16
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [TACC_W-1:0]              in_a,
   input  logic [TACC_W-1:0]              in_b,
   input  logic                           in_b_en,
   input  logic                           in_cin,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [TACC_W-1:0]              out_sum,
   output logic                           out_err,
   output logic [$clog2(MAX_BEATS+1)-1:0] out_beats
`ifdef TERNARY_ACC_PERF_EN
   ,
   output logic [TACC_PERF_W-1:0]         perf_bursts,
   output logic [TACC_PERF_W-1:0]         perf_trunc
`endif
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   tacc_state_t        r_state;
   tacc_state_t        w_state_nx;
   logic [TACC_W-1:0]  r_acc;
   logic [TACC_W-1:0]  w_sum;
   logic [TACC_W-1:0]  w_z;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_accept;
   logic               w_close;
   logic               w_cin;
   logic               w_out_hs;

   assign w_accept  = in_valid && in_ready;
   assign w_out_hs  = out_valid && out_ready;
   assign w_z       = in_b_en ? in_b : '0;
   // Carry-in only on the opening beat, so callers can fold in a single +1.
   assign w_cin     = (r_state == ST_IDLE) && in_cin;
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   ternary_adder_noincr u_adder (
      .i_x   (r_acc),
      .i_y   (in_a),
      .i_z   (w_z),
      .i_cin (w_cin),
      .o_sum (w_sum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_close    = 1'b0;
      case (r_state)
         ST_IDLE, ST_ACC: begin
            if (w_accept) begin
               w_close    = in_last || (w_cnt_inc == CNT_W'(MAX_BEATS));
               w_state_nx = w_close ? ST_OUT : ST_ACC;
            end
         end
         ST_OUT: begin
            if (w_out_hs) w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Handshake flags are registered from next state so in_ready stays low during reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_err   <= 1'b0;
         out_beats <= '0;
      end else begin
         in_ready  <= (w_state_nx != ST_OUT);
         out_valid <= (w_state_nx == ST_OUT);
         if (w_accept) begin
            if (w_close) begin
               r_acc     <= '0;
               r_cnt     <= '0;
               out_sum   <= w_sum;
               out_err   <= !in_last;
               out_beats <= w_cnt_inc;
            end else begin
               r_acc <= w_sum;
               r_cnt <= w_cnt_inc;
            end
         end
         if (w_out_hs) out_err <= 1'b0;
      end
   end

`ifdef TERNARY_ACC_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_bursts <= '0;
         perf_trunc  <= '0;
      end else if (w_out_hs) begin
         perf_bursts <= perf_bursts + TACC_PERF_W'(1);
         if (out_err) perf_trunc <= perf_trunc + TACC_PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ternary_acc_sched.sv
// Randomized scoreboard bench for ternary_acc_sched with directed corner bursts.
module tb_ternary_acc_sched;
   import ternary_acc_pkg::*;

   localparam int MB = 4;
   localparam int BW = $clog2(MB + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_a = '0;
   logic [7:0]    in_b = '0;
   logic          in_b_en = 1'b0;
   logic          in_cin = 1'b0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [7:0]    out_sum;
   logic          out_err;
   logic [BW-1:0] out_beats;
`ifdef TERNARY_ACC_PERF_EN
   logic [15:0]   perf_bursts;
   logic [15:0]   perf_trunc;
   int            exp_bursts = 0;
   int            exp_trunc  = 0;
`endif

   typedef struct {
      int sum;
      int err;
      int beats;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_sum = 0;
   int   m_cnt = 0;
   int   ready_mode = 0;   // 0 random, 1 held low, 2 held high

   ternary_acc_sched #(.MAX_BEATS(MB)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_b_en   (in_b_en),
      .in_cin    (in_cin),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_err   (out_err),
      .out_beats (out_beats)
`ifdef TERNARY_ACC_PERF_EN
      ,
      .perf_bursts (perf_bursts),
      .perf_trunc  (perf_trunc)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Burst-level reference: plain integer sum, cin counted once per burst.
   function automatic bit model_beat(input int a, input int b, input bit ben,
                                     input bit cin, input bit last);
      if (m_cnt == 0) m_sum += int'(cin);
      m_sum += a + (ben ? b : 0);
      m_cnt++;
      if (last || m_cnt == MB) begin
         exp_q.push_back('{m_sum % 256, last ? 0 : 1, m_cnt});
         m_sum = 0;
         m_cnt = 0;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic send(input int a, input int b, input bit ben, input bit cin, input bit last);
      int  waited;
      bit  closed;
      waited = 0;
      @(negedge clk);
      in_a = 8'(a); in_b = 8'(b); in_b_en = ben; in_cin = cin; in_last = last;
      in_valid = 1'b1;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) begin
         check("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      closed = model_beat(a, b, ben, cin, last);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = 8'($urandom);
      in_cin = 1'($urandom);
      if (closed) begin
         check("latency_out_valid", int'(out_valid), 1);
         check("in_ready_low_in_out", int'(in_ready), 0);
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Monitor: drives out_ready, compares every output handshake against the queue.
   initial begin
      exp_t e;
      bit   prev_stall;
      int   prev_sum;
      prev_stall = 1'b0;
      prev_sum   = 0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         #1;
         if (reset) begin
            prev_stall = 1'b0;
`ifdef TERNARY_ACC_PERF_EN
            exp_bursts = 0;
            exp_trunc  = 0;
`endif
         end else begin
            if (out_valid && prev_stall) check("out_sum_stable", int'(out_sum), prev_sum);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_sum", int'(out_sum), e.sum);
                  check("out_err", int'(out_err), e.err);
                  check("out_beats", int'(out_beats), e.beats);
`ifdef TERNARY_ACC_PERF_EN
                  check("perf_bursts", int'(perf_bursts), exp_bursts % 65536);
                  check("perf_trunc", int'(perf_trunc), exp_trunc % 65536);
                  exp_bursts++;
                  if (e.err != 0) exp_trunc++;
`endif
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = int'(out_sum);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum", int'(out_sum), 0);
      check("rst_out_err", int'(out_err), 0);
      check("rst_out_beats", int'(out_beats), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_release", int'(in_ready), 1);

      // Basic burst and odd operand / wrap cases.
      send(10, 20, 1, 0, 0);
      send(30, 40, 1, 0, 1);
      send(200, 100, 0, 0, 1);
      send(200, 100, 1, 0, 0);
      send(0, 0, 1, 0, 1);
      // Subtraction via cin, then cin ignored on a later beat.
      send(100, 250, 1, 1, 1);
      send(100, 250, 1, 1, 0);
      send(10, 0, 1, 1, 1);
      // Truncation at MAX_BEATS; the fifth beat opens a new burst.
      for (int i = 0; i < 5; i++) send(1, 1, 1, 0, 0);
      send(1, 1, 1, 0, 1);
      drain();

      // Backpressure: result must hold while out_ready is low.
      ready_mode = 1;
      send(5, 6, 1, 0, 1);
      repeat (3) begin
         @(negedge clk);
         #2;
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_out_sum", int'(out_sum), 11);
      end
      ready_mode = 2;
      @(negedge clk);
      @(posedge clk);
      #1;
      check("release_in_ready", int'(in_ready), 1);
      check("release_out_valid", int'(out_valid), 0);
      ready_mode = 0;
      drain();

      // Reset mid-burst discards the partial result.
      send(50, 60, 1, 0, 0);
      send(70, 80, 1, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      m_sum = 0;
      m_cnt = 0;
      #1;
      check("mid_rst_in_ready", int'(in_ready), 0);
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_out_sum", int'(out_sum), 0);
      check("mid_rst_out_beats", int'(out_beats), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send(7, 8, 1, 0, 1);
      drain();

      // Random bursts with random gaps and backpressure.
      for (int i = 0; i < 300; i++) begin
         send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send(1, 2, 1, 0, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
